issue_ctrl: RTL and testbench
=============================

// Module: issue_ctrl
// PURPOSE
// Issue-stage controller between the InstQueue and the reservation stations/ROB. Pops one instruction into a
// one-entry hold register and presents it to the Decoder. Uses the Decoder's unit class to dispatch the
// instruction to the ALU, Branch or LSB RS when that RS and the ROB have room. Allocates ROB tags in order,
// tracks ROB occupancy and discards all state on a misprediction flush.
// PARAMETERS
// ROB_TAG_W  4   ROB tag width; ROB depth = 2**ROB_TAG_W (16)
// INST_W     32  instruction width (`InstWidth)
// ADDR_W     32  pc width (`AddrWidth)
// OPID_W     6   Decoder OP_ID width (`OpIdBus)
// PORTS
// clk             in   1          clock, all state on posedge
// rst             in   1          synchronous, active-high reset
// rdy             in   1          0 -> freeze (see BEHAVIOUR)
// IQ_inst_valid   in   1          IQ head holds a valid instruction
// IQ_inst         in   INST_W     IQ head instruction
// IQ_pc           in   ADDR_W     IQ head pc
// IQ_enable       out  1          pop IQ head this cycle (combinational)
// DEC_inst        out  INST_W     held instruction, to Decoder
// DEC_pc          out  ADDR_W     held pc, to Decoder
// DEC_class       in   2          Decoder unit class of DEC_inst: 00 ALU, 01 BR, 10 LSB, 11 invalid
// DEC_OP_ID       in   OPID_W     Decoder OP_ID of DEC_inst
// ALURS_is_full   in   1          ALU RS cannot accept
// BRRS_is_full    in   1          Branch RS cannot accept
// LSBRS_is_full   in   1          LSB RS cannot accept
// ROB_commit      in   1          ROB retired one entry this cycle
// ROB_flush       in   1          mispredict: discard everything in flight
// ALURS_enable    out  1          1-cycle dispatch pulse, ALU RS (registered)
// BRRS_enable     out  1          1-cycle dispatch pulse, Branch RS (registered)
// LSBRS_enable    out  1          1-cycle dispatch pulse, LSB RS (registered)
// ROB_enable      out  1          allocate ROB entry; same cycle as any *RS_enable
// disp_pc         out  ADDR_W     dispatched pc
// disp_OP_ID      out  OPID_W     dispatched OP_ID
// disp_rob_tag    out  ROB_TAG_W  tag given to the dispatched instruction
// BEHAVIOUR
// - Reset: state=IDLE, hold regs 0, alloc_tag=0, rob_cnt=0; all enables 0; disp_* 0; DEC_inst/DEC_pc 0.
// - FSM: IDLE (hold empty) / HOLD (hold full).
// - IDLE: IQ_enable = IQ_inst_valid & rdy & !ROB_flush; a pop loads the hold regs -> HOLD.
// - HOLD: go = (DEC_class!=11) & !targetRS_is_full & (rob_cnt < 2**ROB_TAG_W).
//   - On go: next cycle drive target *RS_enable=1 and ROB_enable=1 with disp_pc/disp_OP_ID/disp_rob_tag=alloc_tag.
//     Then alloc_tag += 1 (mod 2**W, wraps 15->0) and rob_cnt += 1.
//   - On class 11: drop the instruction; no pulse, no tag, counters unchanged.
//   - go or drop frees the hold reg in the same cycle: IQ_enable = IQ_inst_valid & rdy & !ROB_flush.
//     On refill stay HOLD, else -> IDLE. Back-to-back throughput is 1 instruction per cycle.
//   - No go and no drop: stall, IQ_enable=0, hold unchanged.
// - rob_cnt (W+1 bits) next = rob_cnt + alloc - ROB_commit. Simultaneous alloc+commit leaves it unchanged.
//   Commit at rob_cnt=0 is ignored (no underflow).
// - ROB_flush (priority over everything except rst): next cycle state=IDLE, rob_cnt=0, alloc_tag=0, all pulses 0;
//   IQ_enable=0 during the flush cycle. A commit or go in the same cycle is discarded.
// - rdy=0: IQ_enable=0; hold/FSM/counters frozen; *_enable pulses 0 next edge; disp_* payload held.
// - Pulses last exactly one cycle; at most one *RS_enable is high per cycle.
// STRUCTURE
// - `defines.v: class codes (`CLASS_ALU/BR/LSB/INV), ROB depth and tag width, `OpIdBus, `True/`False.
// - One natural sub-module, issue_tag_alloc: alloc_tag + rob_cnt with inputs alloc/commit/flush and
//   outputs tag/full. FSM, hold register and dispatch mux stay in issue_ctrl.
// TESTING
// 1 rst held 2 cycles with IQ_inst_valid=1 -> IQ_enable=0, all enables 0, rob_cnt=0.
// 2 3 ALU instructions back-to-back, RS empty -> ALURS_enable/ROB_enable high 3 consecutive cycles, tags 0,1,2.
// 3 BR instruction held with BRRS_is_full=1 for 4 cycles -> no pulse, IQ_enable=0; release -> 1 BRRS pulse.
// 4 16 dispatches with no commit -> 17th stalls; ROB_commit=1 in that cycle -> dispatched next cycle,
//   tag=0 (wrap), rob_cnt stays 16.
// 5 ROB_flush while HOLD with go=1 -> no pulse next cycle, state IDLE, next dispatch gets tag 0.
// 6 DEC_class=11 -> dropped silently, following ALU instruction gets tag unchanged;
//   rdy=0 mid-stream freezes tag and pulses.

Source files
------------

// File: rtl/issue_ctrl_pkg.sv
// Shared types and sizing for the issue-stage controller.
// Holds the Decoder unit-class codes, FSM state encoding and default widths.
// Modules import this and use the widths as parameter defaults.
package issue_ctrl_pkg;

  localparam int ROB_TAG_W = 4;
  localparam int ROB_DEPTH = 1 << ROB_TAG_W;
  localparam int INST_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int OPID_W    = 6;

  // Decoder unit class of the held instruction.
  typedef enum logic [1:0] {
    CLASS_ALU = 2'b00,
    CLASS_BR  = 2'b01,
    CLASS_LSB = 2'b10,
    CLASS_INV = 2'b11
  } unit_class_e;

  // IDLE: hold register empty, HOLD: hold register full.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } issue_state_e;

  // Only the three real execution classes can be dispatched.
  function automatic logic class_dispatchable(input unit_class_e cls);
    return cls != CLASS_INV;
  endfunction

endpackage

// File: rtl/issue_tag_alloc.sv
// ROB tag allocator and occupancy counter for the issue stage.
// Latency: tag/full reflect allocations and commits from the previous edge.
// Backpressure: o_full stays high while all ROB entries are allocated; commits free entries.
module issue_tag_alloc
  import issue_ctrl_pkg::*;
#(
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_alloc,
  input  logic             i_commit,
  input  logic             i_flush,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_full
);

  localparam int           DEPTH    = 1 << TAG_W;
  localparam logic [TAG_W-1:0] TAG_ONE  = 1;
  localparam logic [TAG_W:0]   CNT_ONE  = 1;
  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W + 1)'(DEPTH);

  logic [TAG_W-1:0] r_tag;
  logic [TAG_W:0]   r_cnt;
  logic             w_commit_eff;
  logic [TAG_W:0]   w_cnt_nxt;

  // A commit against an empty ROB is a no-op so the count never underflows.
  assign w_commit_eff = i_commit & (r_cnt != '0);

  // Occupancy update: simultaneous alloc and commit cancel out.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_alloc && !w_commit_eff) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end else if (!i_alloc && w_commit_eff) begin
      w_cnt_nxt = r_cnt - CNT_ONE;
    end
  end

  // Tag and count registers; a flush returns the ROB to empty with tag 0.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_tag <= '0;
      r_cnt <= '0;
    end else begin
      if (i_alloc) begin
        r_tag <= r_tag + TAG_ONE;
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_tag  = r_tag;
  assign o_full = (r_cnt == CNT_FULL);

endmodule

// File: rtl/issue_ctrl.sv
// Issue-stage controller: pops the InstQueue into a hold register and dispatches to ALU/BR/LSB RS + ROB.
// Latency: one cycle IQ->hold, dispatch pulse one cycle after the go decision; 1 instr/cycle sustained.
// Backpressure: stalls in HOLD while target RS or ROB is full; rdy=0 freezes; flush clears everything.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int ROB_TAG_W_P = ROB_TAG_W,
  parameter int INST_W_P    = INST_W,
  parameter int ADDR_W_P    = ADDR_W,
  parameter int OPID_W_P    = OPID_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rdy,
  input  logic                   i_iq_inst_valid,
  input  logic [INST_W_P-1:0]    i_iq_inst,
  input  logic [ADDR_W_P-1:0]    i_iq_pc,
  output logic                   o_iq_enable,
  output logic [INST_W_P-1:0]    o_dec_inst,
  output logic [ADDR_W_P-1:0]    o_dec_pc,
  input  logic [1:0]             i_dec_class,
  input  logic [OPID_W_P-1:0]    i_dec_op_id,
  input  logic                   i_alurs_is_full,
  input  logic                   i_brrs_is_full,
  input  logic                   i_lsbrs_is_full,
  input  logic                   i_rob_commit,
  input  logic                   i_rob_flush,
  output logic                   o_alurs_enable,
  output logic                   o_brrs_enable,
  output logic                   o_lsbrs_enable,
  output logic                   o_rob_enable,
  output logic [ADDR_W_P-1:0]    o_disp_pc,
  output logic [OPID_W_P-1:0]    o_disp_op_id,
  output logic [ROB_TAG_W_P-1:0] o_disp_rob_tag
);

  issue_state_e           r_state;
  issue_state_e           w_state_nxt;
  logic [INST_W_P-1:0]    r_hold_inst;
  logic [ADDR_W_P-1:0]    r_hold_pc;
  logic                   r_alu_en;
  logic                   r_br_en;
  logic                   r_lsb_en;
  logic                   r_rob_en;
  logic [ADDR_W_P-1:0]    r_disp_pc;
  logic [OPID_W_P-1:0]    r_disp_op_id;
  logic [ROB_TAG_W_P-1:0] r_disp_tag;

  unit_class_e            w_class;
  logic                   w_target_full;
  logic                   w_active;
  logic                   w_go;
  logic                   w_drop;
  logic                   w_pop;
  logic                   w_rob_full;
  logic [ROB_TAG_W_P-1:0] w_alloc_tag;

  assign w_class = unit_class_e'(i_dec_class);

  // Nothing moves while frozen, flushing or in reset.
  assign w_active = i_rdy & ~i_rob_flush & ~i_rst;

  // Select the full flag of the RS the held instruction is headed for.
  always_comb begin
    w_target_full = 1'b1;
    case (w_class)
      CLASS_ALU: w_target_full = i_alurs_is_full;
      CLASS_BR:  w_target_full = i_brrs_is_full;
      CLASS_LSB: w_target_full = i_lsbrs_is_full;
      default:   w_target_full = 1'b1;
    endcase
  end

  // FSM next state plus go/drop/pop decisions; a freed hold slot may refill in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_drop      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pop = i_iq_inst_valid & w_active;
        if (w_pop) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_go   = w_active & class_dispatchable(w_class) & ~w_target_full & ~w_rob_full;
        w_drop = w_active & (w_class == CLASS_INV);
        if (w_go || w_drop) begin
          w_pop       = i_iq_inst_valid & w_active;
          w_state_nxt = w_pop ? ST_HOLD : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_rob_flush) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Hold register: captures the IQ head whenever it is popped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_inst <= '0;
      r_hold_pc   <= '0;
    end else if (w_pop) begin
      r_hold_inst <= i_iq_inst;
      r_hold_pc   <= i_iq_pc;
    end
  end

  // Dispatch outputs: one-cycle pulses on go; payload persists until the next dispatch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alu_en     <= 1'b0;
      r_br_en      <= 1'b0;
      r_lsb_en     <= 1'b0;
      r_rob_en     <= 1'b0;
      r_disp_pc    <= '0;
      r_disp_op_id <= '0;
      r_disp_tag   <= '0;
    end else begin
      r_alu_en <= w_go & (w_class == CLASS_ALU);
      r_br_en  <= w_go & (w_class == CLASS_BR);
      r_lsb_en <= w_go & (w_class == CLASS_LSB);
      r_rob_en <= w_go;
      if (w_go) begin
        r_disp_pc    <= r_hold_pc;
        r_disp_op_id <= i_dec_op_id;
        r_disp_tag   <= w_alloc_tag;
      end
    end
  end

  // Commits are frozen along with everything else while rdy is low.
  issue_tag_alloc #(
    .TAG_W(ROB_TAG_W_P)
  ) u_tag_alloc (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_alloc  (w_go),
    .i_commit (i_rob_commit & i_rdy),
    .i_flush  (i_rob_flush),
    .o_tag    (w_alloc_tag),
    .o_full   (w_rob_full)
  );

  assign o_iq_enable    = w_pop;
  assign o_dec_inst     = r_hold_inst;
  assign o_dec_pc       = r_hold_pc;
  assign o_alurs_enable = r_alu_en;
  assign o_brrs_enable  = r_br_en;
  assign o_lsbrs_enable = r_lsb_en;
  assign o_rob_enable   = r_rob_en;
  assign o_disp_pc      = r_disp_pc;
  assign o_disp_op_id   = r_disp_op_id;
  assign o_disp_rob_tag = r_disp_tag;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: acts as InstQueue and Decoder, scoreboards every dispatch pulse.
// Decoder model: class = inst[1:0], OP_ID = inst[7:2].
// Directed sequences cover reset, back-to-back, RS stall, flush, ROB full/wrap, drop and rdy freeze.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  typedef struct {
    logic [1:0]  unit;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        iq_valid;
  logic [31:0] iq_inst, iq_pc;
  logic        iq_enable;
  logic [31:0] dec_inst, dec_pc;
  logic [1:0]  dec_class;
  logic [5:0]  dec_op_id;
  logic        alu_full, br_full, lsb_full;
  logic        rob_commit, rob_flush;
  logic        alu_en, br_en, lsb_en, rob_en;
  logic [31:0] disp_pc;
  logic [5:0]  disp_op;
  logic [3:0]  disp_tag;

  exp_t        exp_q[$];
  logic [31:0] iqi_q[$];
  logic [31:0] iqp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign dec_class = dec_inst[1:0];
  assign dec_op_id = dec_inst[7:2];

  issue_ctrl dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_rdy           (rdy),
    .i_iq_inst_valid (iq_valid),
    .i_iq_inst       (iq_inst),
    .i_iq_pc         (iq_pc),
    .o_iq_enable     (iq_enable),
    .o_dec_inst      (dec_inst),
    .o_dec_pc        (dec_pc),
    .i_dec_class     (dec_class),
    .i_dec_op_id     (dec_op_id),
    .i_alurs_is_full (alu_full),
    .i_brrs_is_full  (br_full),
    .i_lsbrs_is_full (lsb_full),
    .i_rob_commit    (rob_commit),
    .i_rob_flush     (rob_flush),
    .o_alurs_enable  (alu_en),
    .o_brrs_enable   (br_en),
    .o_lsbrs_enable  (lsb_en),
    .o_rob_enable    (rob_en),
    .o_disp_pc       (disp_pc),
    .o_disp_op_id    (disp_op),
    .o_disp_rob_tag  (disp_tag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] cls, input logic [5:0] op, input logic [31:0] pc);
    return {pc[23:0], op, cls};
  endfunction

  task automatic drive_iq();
    iq_valid = (iqi_q.size() > 0);
    iq_inst  = (iqi_q.size() > 0) ? iqi_q[0] : 32'd0;
    iq_pc    = (iqp_q.size() > 0) ? iqp_q[0] : 32'd0;
  endtask

  // Enqueue one instruction into the IQ model; expected dispatches go onto the scoreboard.
  task automatic iq_push(input logic [1:0] cls, input logic [5:0] op, input logic [31:0] pc,
                         input bit will_disp, input logic [3:0] tag);
    exp_t e;
    iqi_q.push_back(mk(cls, op, pc));
    iqp_q.push_back(pc);
    if (will_disp) begin
      e.unit = cls;
      e.pc   = pc;
      e.op   = op;
      e.tag  = tag;
      exp_q.push_back(e);
    end
    drive_iq();
  endtask

  // Advance one clock; pop the IQ model if the DUT asserted IQ_enable before the edge.
  task automatic tick();
    bit pop;
    @(negedge clk);
    pop = iq_enable;
    @(posedge clk);
    #1;
    if (pop && iqi_q.size() > 0) begin
      void'(iqi_q.pop_front());
      void'(iqp_q.pop_front());
    end
    drive_iq();
  endtask

  // Scoreboard monitor: every dispatch pulse is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] u;
    int         hot;
    if (alu_en === 1'b1 || br_en === 1'b1 || lsb_en === 1'b1 || rob_en === 1'b1) begin
      n_cmp++;
      hot = int'(alu_en) + int'(br_en) + int'(lsb_en);
      u   = br_en ? 2'b01 : (lsb_en ? 2'b10 : 2'b00);
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_dispatch: unit=%0d pc=%0h tag=%0d, none expected", u, disp_pc, disp_tag);
      end else begin
        e = exp_q.pop_front();
        if (hot != 1 || rob_en !== 1'b1 || u != e.unit || disp_pc !== e.pc ||
            disp_op !== e.op || disp_tag !== e.tag) begin
          n_bad++;
          $display("FAIL dispatch: got unit=%0d hot=%0d rob=%0b pc=%0h op=%0h tag=%0d, want unit=%0d pc=%0h op=%0h tag=%0d",
                   u, hot, rob_en, disp_pc, disp_op, disp_tag, e.unit, e.pc, e.op, e.tag);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rdy = 1'b1;
    alu_full = 1'b0; br_full = 1'b0; lsb_full = 1'b0;
    rob_commit = 1'b0; rob_flush = 1'b0;
    drive_iq();

    // Reset with a valid IQ head: nothing pops, everything reads zero.
    iq_push(CLASS_ALU, 6'h01, 32'h100, 1'b1, 4'd0);
    iq_push(CLASS_ALU, 6'h02, 32'h104, 1'b1, 4'd1);
    iq_push(CLASS_ALU, 6'h03, 32'h108, 1'b1, 4'd2);
    for (int i = 0; i < 2; i++) begin
      #1 chk("rst_iq_enable", 32'(iq_enable), 0);
      tick();
      chk("rst_enables", 32'({alu_en, br_en, lsb_en, rob_en}), 0);
      chk("rst_disp", 32'({disp_pc, disp_op, disp_tag} != '0), 0);
      chk("rst_dec_inst", dec_inst, 0);
    end
    rst = 1'b0;

    // Three ALU instructions back-to-back: three consecutive pulses, tags 0,1,2.
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b_alu_pulse", 32'(alu_en), 1);
      chk("b2b_rob_pulse", 32'(rob_en), 1);
    end
    tick();
    chk("b2b_pulse_end", 32'({alu_en, rob_en}), 0);

    // Branch held against a full Branch RS, then released.
    br_full = 1'b1;
    iq_push(CLASS_BR, 6'h10, 32'h200, 1'b1, 4'd3);
    iq_push(CLASS_ALU, 6'h11, 32'h204, 1'b1, 4'd4);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1 chk("br_stall_iq_enable", 32'(iq_enable), 0);
      tick();
      chk("br_stall_no_pulse", 32'({br_en, rob_en}), 0);
    end
    br_full = 1'b0;
    tick();
    chk("br_release_pulse", 32'(br_en), 1);
    tick();
    chk("alu_after_br", 32'({alu_en, br_en}), 32'h2);

    // Flush while the held instruction would go; same-cycle commit is discarded.
    iq_push(CLASS_ALU, 6'h20, 32'h300, 1'b0, 4'd0);
    iq_push(CLASS_ALU, 6'h21, 32'h304, 1'b1, 4'd0);
    tick();
    rob_flush = 1'b1; rob_commit = 1'b1;
    #1 chk("flush_iq_enable", 32'(iq_enable), 0);
    tick();
    chk("flush_no_pulse", 32'({alu_en, rob_en}), 0);
    rob_flush = 1'b0; rob_commit = 1'b0;
    #1 chk("flush_idle_pop", 32'(iq_enable), 1);
    tick();

    // Sixteen dispatches fill the ROB; the seventeenth waits for a commit and wraps to tag 0.
    for (int i = 1; i < 16; i++) begin
      iq_push(CLASS_ALU, 6'(i), 32'h400 + 4 * i, 1'b1, 4'(i));
    end
    iq_push(CLASS_ALU, 6'h3f, 32'h500, 1'b1, 4'd0);
    repeat (16) tick();
    chk("fill_last_pulse_tag", 32'(disp_tag), 15);
    rob_commit = 1'b1;
    tick();
    chk("rob_full_stall", 32'(alu_en), 0);
    rob_commit = 1'b0;
    tick();
    chk("wrap_dispatch", 32'(alu_en), 1);
    chk("wrap_tag", 32'(disp_tag), 0);

    // Invalid class dropped; following ALU still sees a full ROB, then takes tag 1.
    iq_push(CLASS_INV, 6'h2a, 32'h600, 1'b0, 4'd0);
    iq_push(CLASS_ALU, 6'h2b, 32'h604, 1'b1, 4'd1);
    tick();
    tick();
    chk("drop_no_pulse", 32'({alu_en, br_en, lsb_en, rob_en}), 0);
    tick();
    chk("full_after_drop", 32'(alu_en), 0);
    rob_commit = 1'b1;
    tick();
    rob_commit = 1'b0;
    tick();
    chk("alu_after_drop", 32'(alu_en), 1);
    chk("alu_after_drop_tag", 32'(disp_tag), 1);

    // rdy low mid-stream freezes pops, pulses and the payload.
    rob_commit = 1'b1;
    repeat (3) tick();
    rob_commit = 1'b0;
    iq_push(CLASS_ALU, 6'h30, 32'h700, 1'b1, 4'd2);
    iq_push(CLASS_ALU, 6'h31, 32'h704, 1'b1, 4'd3);
    iq_push(CLASS_ALU, 6'h32, 32'h708, 1'b1, 4'd4);
    tick();
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("rdy0_iq_enable", 32'(iq_enable), 0);
      tick();
      chk("rdy0_no_pulse", 32'({alu_en, rob_en}), 0);
      chk("rdy0_tag_held", 32'(disp_tag), 2);
    end
    rdy = 1'b1;
    tick();
    chk("rdy1_resume_tag", 32'(disp_tag), 3);
    tick();
    chk("rdy1_next_tag", 32'(disp_tag), 4);
    tick();
    chk("final_idle", 32'({alu_en, rob_en}), 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("iq_drained", 32'(iqi_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
